reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter W, default 8: data width in bits.
REQ-002 SHALL have parameter D, default 4: address width; 2**D registers.
REQ-003 SHALL have parameter FWD, default 1: 1 enables write-to-read forwarding, 0 disables it.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port write_en, input, 1 bit: write strobe.
REQ-007 SHALL have port waddr, input, D bits: write address.
REQ-008 SHALL have port data_in, input, W bits: write data.
REQ-009 SHALL have port rsv_en, input, 1 bit: reserve strobe; marks a register pending.
REQ-010 SHALL have port rsv_addr, input, D bits: reserve address.
REQ-011 SHALL have ports raddrA and raddrB, input, D bits each: read addresses.
REQ-012 SHALL have ports data_outA and data_outB, output, W bits each: read data.
REQ-013 SHALL have ports readyA and readyB, output, 1 bit each: 1 = read data valid (not pending).
REQ-014 SHALL have port pending_cnt, output, D+1 bits: number of pending registers.

Function
REQ-015 SHALL hold 2**D registers of W bits, plus one pending bit per register.
REQ-016 SHALL perform combinational reads: data_outX = registers[raddrX], readyX = !pending[raddrX].
REQ-017 SHALL hard-wire address 0: reads give 0 with ready=1; writes and reserves to it are ignored.
REQ-018 SHALL, on an edge with write_en=1 and waddr!=0, load data_in into registers[waddr] and clear pending[waddr].
REQ-019 SHALL, on an edge with rsv_en=1 and rsv_addr!=0, set pending[rsv_addr].
REQ-020 SHALL, when a write and a reserve hit the same address in one cycle, write the data and leave pending set (reserve wins).
REQ-021 SHALL leave a register pending with the count unchanged when it is reserved while already pending.
REQ-022 SHALL accept a write to a non-pending register, updating data with pending staying 0.
REQ-023 SHALL, when FWD=1, write_en=1, waddr!=0 and raddrX==waddr, drive data_outX=data_in and readyX=1 in the same cycle.
REQ-024 SHALL, when FWD=0, give the pre-edge register contents and pending state on reads, with no forwarding.
REQ-025 SHALL register pending_cnt so that after every edge it equals the popcount of the pending bits; it never exceeds 2**D-1.
REQ-026 SHALL update pending_cnt incrementally: +1 on a new reserve, -1 on a write to a pending register, 0 net when both occur, per REQ-020/021.
REQ-027 SHALL produce no X on any output for any input combination after reset.

Reset
REQ-028 SHALL, on reset=1 and independent of CLK, clear all registers to 0, all pending bits to 0 and pending_cnt to 0.
REQ-029 SHALL make outputs reflect the cleared state while reset is high: data_out=0, ready=1, pending_cnt=0.
REQ-030 SHALL discard any write or reserve on an edge while reset=1.
REQ-031 SHALL lose all pending reservations when reset asserts mid-operation; no recovery is required.

Verification
REQ-032 SHALL have a bench cover reset then write 0x5A to r3 and read A=3: data_outA=0x5A, readyA=1, pending_cnt=0.
REQ-033 SHALL have a bench cover reserve r5, then read B=5: readyB=0 and pending_cnt=1; then write 0x11 to r5: next cycle readyB=1, data_outB=0x11, pending_cnt=0.
REQ-034 SHALL have a bench cover FWD=1 with write 0xC3 to r7 while raddrA=7 in the same cycle: data_outA=0xC3, readyA=1 before the edge; with FWD=0, data_outA shows the old value.
REQ-035 SHALL have a bench cover a same-cycle write 0x22 and reserve on r2 starting from pending: r2=0x22, pending[2]=1, pending_cnt unchanged.
REQ-036 SHALL have a bench cover write 0xFF to r0, reserve r0, read r0: data_out=0, ready=1, pending_cnt=0.
REQ-037 SHALL have a bench cover reserving r1..r15 (D=4), then asserting reset asynchronously between edges: pending_cnt goes 15 -> 0 immediately, all ready=1, all data=0.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2**D x W register file with per-register pending (scoreboard)
// bits. It has one write port, one reserve port, two combinational read
// ports and a registered count of pending registers. Register 0 is
// hard-wired to zero and is never pending. FWD=1 passes a same-cycle write
// straight through to a matching read port.
module reg_file_sb #(
   parameter int W   = 8,
   parameter int D   = 4,
   parameter int FWD = 1
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         write_en,
   input  logic [D-1:0] waddr,
   input  logic [W-1:0] data_in,
   input  logic         rsv_en,
   input  logic [D-1:0] rsv_addr,
   input  logic [D-1:0] raddrA,
   input  logic [D-1:0] raddrB,
   output logic [W-1:0] data_outA,
   output logic [W-1:0] data_outB,
   output logic         readyA,
   output logic         readyB,
   output logic [D:0]   pending_cnt
);

   localparam int N = 2**D;

   logic [N-1:0][W-1:0] regs;
   logic [N-1:0]        pending;
   logic [N-1:0]        pending_nxt;
   logic [D:0]          cnt;

   logic wr_ok, rsv_ok, inc, dec;

   // Writes and reserves aimed at register 0 are dropped here, so r0 is never
   // written and never marked pending.
   assign wr_ok  = write_en && (waddr != '0);
   assign rsv_ok = rsv_en && (rsv_addr != '0);

   // The count rises only when a reserve sets a bit that was clear. It falls
   // only when a write clears a set bit and no reserve to the same register
   // sets it again in that cycle (the reserve wins).
   assign inc = rsv_ok && !pending[rsv_addr];
   assign dec = wr_ok && pending[waddr] && !(rsv_ok && (rsv_addr == waddr));

   // Next pending vector: the write clears its bit first, then the reserve
   // sets its bit, so the reserve wins on the same address.
   always_comb begin
      pending_nxt = pending;
      if (wr_ok)  pending_nxt[waddr]    = 1'b0;
      if (rsv_ok) pending_nxt[rsv_addr] = 1'b1;
   end

   // Register data storage, cleared asynchronously.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset)      regs        <= '0;
      else if (wr_ok) regs[waddr] <= data_in;
   end

   // Pending bits, cleared asynchronously.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) pending <= '0;
      else       pending <= pending_nxt;
   end

   // Incremental popcount of the pending bits.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) cnt <= '0;
      else begin
         case ({inc, dec})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign pending_cnt = cnt;

   // One read port, returned as {ready, data}. Forwarding is held off during
   // reset so the outputs show only the cleared state.
   function automatic logic [W:0] rd(input logic [D-1:0] a);
      logic [W:0] r;
      r = {!pending[a], regs[a]};
      if (a == '0)
         r = {1'b1, {W{1'b0}}};
      else if ((FWD != 0) && !reset && wr_ok && (waddr == a))
         r = {1'b1, data_in};
      return r;
   endfunction

   assign {readyA, data_outA} = rd(raddrA);
   assign {readyB, data_outB} = rd(raddrB);

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb. Two instances take the same stimulus: one
// with forwarding (FWD=1) and one without (FWD=0). Expected values are
// hand-computed constants.
module tb_reg_file_sb;

   localparam int W = 8;
   localparam int D = 4;

   logic         CLK = 1'b0;
   logic         reset = 1'b1;
   logic         write_en = 1'b0;
   logic [D-1:0] waddr = '0;
   logic [W-1:0] data_in = '0;
   logic         rsv_en = 1'b0;
   logic [D-1:0] rsv_addr = '0;
   logic [D-1:0] raddrA = '0;
   logic [D-1:0] raddrB = '0;

   logic [W-1:0] f_doA, f_doB, n_doA, n_doB;
   logic         f_rdyA, f_rdyB, n_rdyA, n_rdyB;
   logic [D:0]   f_cnt, n_cnt;

   int checks = 0;
   int failures = 0;

   reg_file_sb #(.W(W), .D(D), .FWD(1)) dut (
      .CLK(CLK), .reset(reset), .write_en(write_en), .waddr(waddr),
      .data_in(data_in), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .raddrA(raddrA), .raddrB(raddrB), .data_outA(f_doA), .data_outB(f_doB),
      .readyA(f_rdyA), .readyB(f_rdyB), .pending_cnt(f_cnt));

   reg_file_sb #(.W(W), .D(D), .FWD(0)) dut0 (
      .CLK(CLK), .reset(reset), .write_en(write_en), .waddr(waddr),
      .data_in(data_in), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .raddrA(raddrA), .raddrB(raddrB), .data_outA(n_doA), .data_outB(n_doB),
      .readyA(n_rdyA), .readyB(n_rdyB), .pending_cnt(n_cnt));

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_cnt", 32'(f_cnt), 0);
      check("rst_rdyA", 32'(f_rdyA), 1);
      check("rst_doA", 32'(f_doA), 0);
      tick(); tick();
      #1 reset = 1'b0;

      // Write 0x5A to r3, then read it on port A
      tick();
      write_en = 1; waddr = 3; data_in = 8'h5A; raddrA = 3;
      tick();
      write_en = 0;
      #1;
      check("w3_doA", 32'(f_doA), 32'h5A);
      check("w3_rdyA", 32'(f_rdyA), 1);
      check("w3_cnt", 32'(f_cnt), 0);
      check("w3_doA_nf", 32'(n_doA), 32'h5A);

      // Reserve r5; it stays not-ready until written
      rsv_en = 1; rsv_addr = 5; raddrB = 5;
      tick();
      rsv_en = 0;
      #1;
      check("r5_rdyB", 32'(f_rdyB), 0);
      check("r5_cnt", 32'(f_cnt), 1);
      write_en = 1; waddr = 5; data_in = 8'h11;
      #1;
      check("r5_pre_rdyB_nf", 32'(n_rdyB), 0);
      check("r5_pre_rdyB_f", 32'(f_rdyB), 1);
      tick();
      write_en = 0;
      #1;
      check("r5_rdyB", 32'(f_rdyB), 1);
      check("r5_doB", 32'(f_doB), 32'h11);
      check("r5_cnt0", 32'(f_cnt), 0);

      // Forwarding: r7 holds 0x10, then 0xC3 is written while A reads r7
      write_en = 1; waddr = 7; data_in = 8'h10;
      tick();
      data_in = 8'hC3; raddrA = 7;
      #1;
      check("fwd_doA", 32'(f_doA), 32'hC3);
      check("fwd_rdyA", 32'(f_rdyA), 1);
      check("nofwd_doA", 32'(n_doA), 32'h10);
      tick();
      write_en = 0;
      #1;
      check("fwd_post_doA_nf", 32'(n_doA), 32'hC3);

      // Write and reserve r2 in the same cycle while r2 is already pending
      rsv_en = 1; rsv_addr = 2; raddrA = 2;
      tick();
      check("r2_cnt1", 32'(f_cnt), 1);
      write_en = 1; waddr = 2; data_in = 8'h22;
      tick();
      write_en = 0;
      #1;
      check("r2_doA", 32'(f_doA), 32'h22);
      check("r2_rdyA", 32'(f_rdyA), 0);
      check("r2_cnt", 32'(f_cnt), 1);
      // Reserve again while pending: the count does not change
      tick();
      rsv_en = 0;
      check("r2_rerev_cnt", 32'(f_cnt), 1);
      write_en = 1; waddr = 2; data_in = 8'h33;
      tick();
      write_en = 0;
      #1;
      check("r2_clr_cnt", 32'(f_cnt), 0);
      check("r2_clr_rdyA", 32'(f_rdyA), 1);

      // Register 0 ignores writes and reserves
      write_en = 1; waddr = 0; data_in = 8'hFF; rsv_en = 1; rsv_addr = 0; raddrA = 0;
      #1;
      check("r0_fwd_doA", 32'(f_doA), 0);
      tick();
      write_en = 0; rsv_en = 0;
      #1;
      check("r0_doA", 32'(f_doA), 0);
      check("r0_rdyA", 32'(f_rdyA), 1);
      check("r0_cnt", 32'(f_cnt), 0);

      // Reserve r1..r15, then assert reset between edges
      for (int i = 1; i < 16; i++) begin
         rsv_en = 1; rsv_addr = 4'(i);
         tick();
      end
      rsv_en = 0; raddrA = 1; raddrB = 15;
      #1;
      check("full_cnt", 32'(f_cnt), 15);
      check("full_cnt_nf", 32'(n_cnt), 15);
      check("full_rdyA", 32'(f_rdyA), 0);
      #2 reset = 1'b1;
      #1;
      check("arst_cnt", 32'(f_cnt), 0);
      check("arst_cnt_nf", 32'(n_cnt), 0);
      for (int i = 0; i < 16; i++) begin
         raddrA = 4'(i); raddrB = 4'(15 - i);
         #1;
         check("arst_rdyA", 32'(f_rdyA), 1);
         check("arst_rdyB", 32'(f_rdyB), 1);
         check("arst_doA", 32'(f_doA), 0);
         check("arst_doB", 32'(n_doB), 0);
      end

      // A write and a reserve on an edge during reset are discarded
      write_en = 1; waddr = 3; data_in = 8'h77; rsv_en = 1; rsv_addr = 3; raddrA = 3;
      #1;
      check("rst_nofwd_doA", 32'(f_doA), 0);
      tick();
      write_en = 0; rsv_en = 0;
      #1;
      check("rst_wr_doA", 32'(f_doA), 0);
      check("rst_wr_cnt", 32'(f_cnt), 0);
      reset = 1'b0;
      tick();
      check("rst_rel_doA", 32'(f_doA), 0);
      check("rst_rel_rdyA", 32'(f_rdyA), 1);

      // Write a pending r4 while reserving r6 in the same cycle: net 0
      rsv_en = 1; rsv_addr = 4;
      tick();
      write_en = 1; waddr = 4; data_in = 8'hA5; rsv_addr = 6; raddrA = 4; raddrB = 6;
      tick();
      write_en = 0; rsv_en = 0;
      #1;
      check("mix_cnt", 32'(f_cnt), 1);
      check("mix_rdyA", 32'(f_rdyA), 1);
      check("mix_doA", 32'(f_doA), 32'hA5);
      check("mix_rdyB", 32'(f_rdyB), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
